// File: rtl/mod_updown_counter_pkg.sv
// Shared types for the modulo-N up/down counter: per-edge operation select and its priority decode.
package mod_updown_counter_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_STEP = 2'd1,
    OP_LOAD = 2'd2,
    OP_CLR  = 2'd3
  } op_e;

  // Priority is clr > load > en > hold.
  function automatic op_e decode_op(input logic clr, input logic load, input logic en);
    if (clr)       return OP_CLR;
    else if (load) return OP_LOAD;
    else if (en)   return OP_STEP;
    else           return OP_HOLD;
  endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-state and terminal-count logic for the modulo-N up/down counter.
module mod_counter_next
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 8,
  parameter int INIT   = 0
) (
  input  logic [WIDTH-1:0] out,
  input  logic             up,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_out,
  output logic             tc
);

  // One extra bit so MODULO == 2**WIDTH still decodes LAST and the load clamp correctly.
  localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULO - 1);
  localparam logic [WIDTH:0] ONE  = (WIDTH+1)'(1);

  logic [WIDTH:0] out_ext;
  logic [WIDTH:0] load_ext;
  logic           at_last;
  logic           at_zero;
  op_e            op;

  assign out_ext  = {1'b0, out};
  assign load_ext = {1'b0, load_val};
  assign at_last  = (out_ext == LAST);
  assign at_zero  = (out_ext == '0);
  assign op       = decode_op(clr, load, en);

  always_comb begin
    next_out = out;
    tc       = 1'b0;
    unique case (op)
      OP_CLR:  next_out = WIDTH'(INIT);
      OP_LOAD: next_out = (load_ext > LAST) ? LAST[WIDTH-1:0] : load_val;
      OP_STEP: begin
        tc = up ? at_last : at_zero;
        if (up)
          next_out = at_last ? '0 : WIDTH'(out_ext + ONE);
        else
          next_out = at_zero ? LAST[WIDTH-1:0] : WIDTH'(out_ext - ONE);
      end
      default: next_out = out;
    endcase
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with clear, clamped load, terminal-count lookahead,
// registered wrap pulse and saturating wrap counter.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 8,
  parameter int INIT   = 0,
  parameter int WCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              up,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  out,
  output logic              tc,
  output logic              wrap,
  output logic [WCNT_W-1:0] wrap_cnt
);

  if (WIDTH < 1 || WIDTH > 16 || MODULO < 2 || MODULO > (1 << WIDTH) ||
      INIT < 0 || INIT >= MODULO || WCNT_W < 1) begin : g_bad_params
    $error("mod_updown_counter: illegal WIDTH/MODULO/INIT/WCNT_W combination");
  end

  logic [WIDTH-1:0]  out_reg;
  logic [WIDTH-1:0]  out_next;
  logic              wrap_reg;
  logic [WCNT_W-1:0] wrap_cnt_reg;
  logic              is_clr;

  mod_counter_next #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO),
    .INIT   (INIT)
  ) u_next (
    .out      (out_reg),
    .up       (up),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .next_out (out_next),
    .tc       (tc)
  );

  assign is_clr = (decode_op(clr, load, en) == OP_CLR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg      <= WIDTH'(INIT);
      wrap_reg     <= 1'b0;
      wrap_cnt_reg <= '0;
    end else begin
      out_reg  <= out_next;
      wrap_reg <= tc;
      // Saturate instead of rolling over so a long run never reads as "few wraps".
      if (is_clr)
        wrap_cnt_reg <= '0;
      else if (tc && (wrap_cnt_reg != '1))
        wrap_cnt_reg <= wrap_cnt_reg + 1'b1;
    end
  end

  assign out      = out_reg;
  assign wrap     = wrap_reg;
  assign wrap_cnt = wrap_cnt_reg;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench: three counter configurations driven in lockstep, checked against a modulo-arithmetic model and a vector table.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] out_a, out_s, out_f;
  logic       tc_a, tc_s, tc_f;
  logic       wrap_a, wrap_s, wrap_f;
  logic [7:0] wcnt_a, wcnt_f;
  logic [1:0] wcnt_s;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MODULO(8), .INIT(0), .WCNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .out(out_a), .tc(tc_a), .wrap(wrap_a), .wrap_cnt(wcnt_a));
  mod_updown_counter #(.WIDTH(4), .MODULO(2), .INIT(0), .WCNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .out(out_s), .tc(tc_s), .wrap(wrap_s), .wrap_cnt(wcnt_s));
  mod_updown_counter #(.WIDTH(4), .MODULO(16), .INIT(0), .WCNT_W(8)) dut_f (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .out(out_f), .tc(tc_f), .wrap(wrap_f), .wrap_cnt(wcnt_f));

  int act_out[3], act_tc[3], act_wrap[3], act_wcnt[3];
  always_comb begin
    act_out[0] = int'(out_a);  act_out[1] = int'(out_s);  act_out[2] = int'(out_f);
    act_tc[0] = int'(tc_a);    act_tc[1] = int'(tc_s);    act_tc[2] = int'(tc_f);
    act_wrap[0] = int'(wrap_a); act_wrap[1] = int'(wrap_s); act_wrap[2] = int'(wrap_f);
    act_wcnt[0] = int'(wcnt_a); act_wcnt[1] = int'(wcnt_s); act_wcnt[2] = int'(wcnt_f);
  end

  int passed = 0;
  int total = 0;

  // Reference model: count value in 0..mod-1, wrap flag, saturating wrap count.
  int mod_v[3] = '{8, 2, 16};
  int wmax[3]  = '{255, 3, 255};
  int m_out[3], m_wrap[3], m_wcnt[3];

  typedef struct {
    logic       en, up, clr, load;
    logic [3:0] lv;
    int         tc, out, wrap, wcnt;
  } vec_t;
  vec_t vecs[17];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int model_tc(input int i);
    if (!en || clr || load) return 0;
    if (up) return (m_out[i] == mod_v[i] - 1) ? 1 : 0;
    return (m_out[i] == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_out[i] = 0; m_wrap[i] = 0; m_wcnt[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int t;
      t = model_tc(i);
      if (clr) begin
        m_out[i] = 0; m_wcnt[i] = 0;
      end else if (load) begin
        m_out[i] = (int'(load_val) < mod_v[i]) ? int'(load_val) : mod_v[i] - 1;
      end else if (en) begin
        m_out[i] = (m_out[i] + (up ? 1 : mod_v[i] - 1)) % mod_v[i];
        if (t == 1 && m_wcnt[i] < wmax[i]) m_wcnt[i]++;
      end
      m_wrap[i] = t;
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s out[%0d]", tag, i), act_out[i], m_out[i]);
      check($sformatf("%s wrap[%0d]", tag, i), act_wrap[i], m_wrap[i]);
      check($sformatf("%s wrap_cnt[%0d]", tag, i), act_wcnt[i], m_wcnt[i]);
    end
  endtask

  // One clock: drive inputs, check tc before the edge, check registers #1 after it.
  task automatic step(input logic e, input logic u, input logic c, input logic l,
                      input logic [3:0] lv, input string tag);
    en = e; up = u; clr = c; load = l; load_val = lv;
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("%s tc[%0d]", tag, i), act_tc[i], model_tc(i));
    @(posedge clk);
    model_edge();
    #1;
    check_regs(tag);
    $display("%s en=%0b up=%0b clr=%0b load=%0b lv=%0d -> out=%0d/%0d/%0d wrap=%0b%0b%0b wcnt=%0d/%0d/%0d",
             tag, e, u, c, l, lv, out_a, out_s, out_f, wrap_a, wrap_s, wrap_f, wcnt_a, wcnt_s, wcnt_f);
  endtask

  // Assert reset between edges with en=1; outputs must clear before the next edge.
  task automatic mid_cycle_reset(input string tag);
    en = 1'b1; up = 1'b1; clr = 1'b0; load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_regs(tag);
    en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_regs({tag, " held"});
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_regs("reset");
    check("reset out_a", int'(out_a), 0);

    // Default configuration (MODULO=8): expected tc before the edge, registers after it.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  0, 1, 0, 0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  0, 2, 0, 0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  0, 3, 0, 0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  0, 4, 0, 0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  0, 5, 0, 0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  0, 6, 0, 0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  0, 7, 0, 0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  1, 0, 1, 1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  0, 1, 0, 1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  0, 1, 0, 1};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd5,  0, 0, 0, 0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1, 7, 1, 1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  0, 6, 0, 1};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  0, 5, 0, 1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd12, 0, 7, 0, 1};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd3,  0, 3, 0, 1};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  0, 4, 0, 1};

    for (int v = 0; v < 17; v++) begin
      en = vecs[v].en; up = vecs[v].up; clr = vecs[v].clr; load = vecs[v].load;
      load_val = vecs[v].lv;
      #1;
      check($sformatf("vec%0d tc", v), int'(tc_a), vecs[v].tc);
      step(vecs[v].en, vecs[v].up, vecs[v].clr, vecs[v].load, vecs[v].lv, $sformatf("vec%0d", v));
      check($sformatf("vec%0d out", v), int'(out_a), vecs[v].out);
      check($sformatf("vec%0d wrap", v), int'(wrap_a), vecs[v].wrap);
      check($sformatf("vec%0d wrap_cnt", v), int'(wcnt_a), vecs[v].wcnt);
    end

    mid_cycle_reset("midreset");

    // MODULO=2, WCNT_W=2: wraps on every 2nd step, counter pins at 3.
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, $sformatf("sat%0d", k));
      check($sformatf("sat%0d wrap_s", k), int'(wrap_s), (k % 2 == 0) ? 1 : 0);
    end
    check("sat wrap_cnt_s", int'(wcnt_s), 3);

    // MODULO=16: 0 -> 15 going down, 15 -> 0 going up; en=0 holds with tc low.
    mid_cycle_reset("fullreset");
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "full_down");
    check("full_down out_f", int'(out_f), 15);
    check("full_down wrap_f", int'(wrap_f), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "full_hold");
    check("full_hold out_f", int'(out_f), 15);
    check("full_hold tc_f", int'(tc_f), 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd15, "full_load");
    check("full_load out_a clamp", int'(out_a), 7);
    #1 en = 1'b1; up = 1'b1; load = 1'b0;
    #1 check("full_up tc_f", int'(tc_f), 1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "full_up");
    check("full_up out_f", int'(out_f), 0);
    check("full_up wrap_cnt_f", int'(wcnt_f), 2);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0,
           $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)), $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
